// File: rtl/pico_drive_pkg.sv
// Shared encodings for the Pico line-follower drive: H-bridge direction codes,
// FSM state codes, sensor classification and the last-seen line side.
package pico_drive_pkg;

   // {JA4,JA3,JA2,JA1}; BACK (4'b0110) is reserved and never driven.
   localparam logic [3:0] DIR_STOP  = 4'b0000;
   localparam logic [3:0] DIR_FWD   = 4'b1001;
   localparam logic [3:0] DIR_RIGHT = 4'b0101;
   localparam logic [3:0] DIR_LEFT  = 4'b1010;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FWD    = 3'd1,
      ST_TURN_L = 3'd2,
      ST_TURN_R = 3'd3,
      ST_SEARCH = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CL_LOST   = 2'd0,
      CL_LEFT   = 2'd1,
      CL_RIGHT  = 2'd2,
      CL_CENTRE = 2'd3
   } class_t;

   typedef enum logic {
      SIDE_RIGHT = 1'b0,
      SIDE_LEFT  = 1'b1
   } side_t;

   // Centre-only, both sides or everything seen all count as CENTRE.
   function automatic class_t classify(input logic any_det, input logic lg, input logic rg);
      if (!any_det)
         return CL_LOST;
      else if (lg && !rg)
         return CL_LEFT;
      else if (rg && !lg)
         return CL_RIGHT;
      return CL_CENTRE;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Two-channel PWM: one free-running counter shared by both channels, each
// output is a registered (counter < duty) compare.
module pwm_gen #(
   parameter int PWM_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_srst,
   input  logic [1:0][PWM_W-1:0] i_duty,
   output logic [1:0]            o_pwm
);

   logic [PWM_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_srst)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + PWM_W'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic r_pwm;
         always_ff @(posedge i_clk) begin
            if (i_srst)
               r_pwm <= 1'b0;
            else
               r_pwm <= (r_cnt < i_duty[gi]);
         end
         assign o_pwm[gi] = r_pwm;
      end
   endgenerate

endmodule

// File: rtl/line_follow_pwm_drive.sv
// Line-follower motor controller: synced/debounced sensors, classification,
// drive FSM with timed lost-line search, latched overcurrent fault, PWM wheels.
module line_follow_pwm_drive
   import pico_drive_pkg::*;
#(
   parameter int               NSENS        = 3,
   parameter int               PWM_W        = 8,
   parameter logic [PWM_W-1:0] DUTY_FWD     = 8'd200,
   parameter logic [PWM_W-1:0] DUTY_TURN    = 8'd80,
   parameter logic [PWM_W-1:0] DUTY_SEARCH  = 8'd120,
   parameter int               DEBOUNCE     = 4,
   parameter int               LOST_TIMEOUT = 1000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       comp_ok,
   input  logic             fault_clr,
   input  logic [NSENS-1:0] sens_n,
   output logic [3:0]       ja,
   output logic             pwm_l,
   output logic             pwm_r,
   output logic [2:0]       state,
   output logic             fault
);

   localparam int C   = NSENS / 2;
   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam int TW  = $clog2(LOST_TIMEOUT + 1);

   logic [NSENS-1:0] r_sync1, r_sync2, r_cand, r_det;
   logic [DBW-1:0]   r_db_cnt;
   state_t           r_state;
   side_t            r_last_side;
   logic [TW-1:0]    r_lost_cnt;
   logic [3:0]       r_ja;
   logic             r_fault;

   state_t                w_state_next;
   class_t                w_class;
   logic [3:0]            w_ja_next;
   logic [1:0][PWM_W-1:0] w_duty;
   logic [1:0]            w_pwm;

   // The mismatch cycle counts as the first of the DEBOUNCE stable cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_cand   <= '1;
         r_db_cnt <= '0;
         r_det    <= '0;
      end else begin
         r_sync1 <= sens_n;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand   <= r_sync2;
            r_db_cnt <= DBW'(1);
         end else if (r_db_cnt < DBW'(DEBOUNCE - 1)) begin
            r_db_cnt <= r_db_cnt + DBW'(1);
         end else begin
            r_det <= ~r_sync2;
         end
      end
   end

   assign w_class = classify(|r_det, |r_det[NSENS-1:C+1], |r_det[C-1:0]);

   always_comb begin
      w_state_next = r_state;
      if (comp_ok != 2'b11) begin
         w_state_next = ST_FAULT;
      end else if (r_state == ST_FAULT) begin
         if (fault_clr)
            w_state_next = ST_IDLE;
      end else if (!enable) begin
         w_state_next = ST_IDLE;
      end else begin
         case (w_class)
            CL_CENTRE: w_state_next = ST_FWD;
            CL_LEFT:   w_state_next = ST_TURN_L;
            CL_RIGHT:  w_state_next = ST_TURN_R;
            default: begin
               // No search without a line having been followed first.
               if (r_state == ST_IDLE)
                  w_state_next = ST_IDLE;
               else if (r_state == ST_SEARCH && r_lost_cnt == TW'(LOST_TIMEOUT - 1))
                  w_state_next = ST_IDLE;
               else
                  w_state_next = ST_SEARCH;
            end
         endcase
      end
   end

   // Drive decoded from the next state so fault shutdown lands one cycle after comp_ok drops.
   always_comb begin
      w_ja_next = DIR_STOP;
      w_duty    = '0;
      case (w_state_next)
         ST_FWD: begin
            w_ja_next = DIR_FWD;
            w_duty    = {DUTY_FWD, DUTY_FWD};
         end
         ST_TURN_L: begin
            w_ja_next = DIR_FWD;
            w_duty    = {DUTY_TURN, DUTY_FWD};
         end
         ST_TURN_R: begin
            w_ja_next = DIR_FWD;
            w_duty    = {DUTY_FWD, DUTY_TURN};
         end
         ST_SEARCH: begin
            w_ja_next = (r_last_side == SIDE_LEFT) ? DIR_LEFT : DIR_RIGHT;
            w_duty    = {DUTY_SEARCH, DUTY_SEARCH};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last_side <= SIDE_RIGHT;
         r_lost_cnt  <= '0;
         r_ja        <= DIR_STOP;
         r_fault     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ja    <= w_ja_next;
         r_fault <= (w_state_next == ST_FAULT);
         if (w_state_next == ST_TURN_L)
            r_last_side <= SIDE_LEFT;
         else if (w_state_next == ST_TURN_R)
            r_last_side <= SIDE_RIGHT;
         if (r_state != ST_SEARCH)
            r_lost_cnt <= '0;
         else
            r_lost_cnt <= r_lost_cnt + TW'(1);
      end
   end

   pwm_gen #(
      .PWM_W (PWM_W)
   ) u_pwm (
      .i_clk  (clock),
      .i_srst (reset),
      .i_duty (w_duty),
      .o_pwm  (w_pwm)
   );

   assign pwm_l = w_pwm[1];
   assign pwm_r = w_pwm[0];
   assign ja    = r_ja;
   assign state = r_state;
   assign fault = r_fault;

endmodule
